// File: rtl/rv32i_pkg.sv
// Shared RV32I constants for the integer register file and its word registers.
// Provides default word width, register count, address width and byte-lane size.
package rv32i_pkg;

  localparam int XLEN       = 32;
  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int BYTE_W     = 8;

  // Number of byte lanes in a word of the given width.
  function automatic int lane_count(input int width);
    return width / BYTE_W;
  endfunction

endpackage

// File: rtl/reg_file_nr1w_reg_word.sv
// reg_word: one WIDTH-bit storage word with per-byte load enables.
// Synchronous active-high reset clears the whole word and overrides any load.
module reg_word
  import rv32i_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [lane_count(WIDTH)-1:0]   ld,
  input  logic [WIDTH-1:0]               d,
  output logic [WIDTH-1:0]               q
);

  localparam int NB = lane_count(WIDTH);

  logic [WIDTH-1:0] q_r;

  // Word storage: clear on reset, otherwise load each enabled byte lane.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (ld[b]) begin
          q_r[b*BYTE_W +: BYTE_W] <= d[b*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  assign q = q_r;

endmodule

// File: rtl/reg_file_nr1w.sv
// reg_file_nr1w: DEPTH x WIDTH register file, one byte-strobed write port,
// NUM_RD combinational read ports, optional hardwired zero word 0.
// Optional feature macro: RF_WRITE_BYPASS_EN (same-cycle write-through on reads).
module reg_file_nr1w
  import rv32i_pkg::*;
#(
  parameter int WIDTH    = XLEN,
  parameter int DEPTH    = REG_COUNT,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              we,
  input  logic [$clog2(DEPTH)-1:0]          waddr,
  input  logic [WIDTH-1:0]                  wdata,
  input  logic [lane_count(WIDTH)-1:0]      wstrb,
  input  logic [NUM_RD*$clog2(DEPTH)-1:0]   raddr,
  output logic [NUM_RD*WIDTH-1:0]           rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = lane_count(WIDTH);

  // Elaboration-time sanity checks on the configuration.
  if ((WIDTH % BYTE_W) != 0 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      NUM_RD < 1 || NUM_RD > 4) begin : g_bad_param
    $error("reg_file_nr1w: illegal parameter combination");
  end

  logic [WIDTH-1:0] word_s [DEPTH];

  // Storage words; word 0 is a constant zero when ZERO_REG is set.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    if (ZERO_REG != 0 && i == 0) begin : g_zero
      assign word_s[i] = '0;
    end else begin : g_reg
      logic [NB-1:0] ld_s;
      assign ld_s = {NB{we & (waddr == AW'(i)) & ~rst}} & wstrb;
      reg_word #(.WIDTH(WIDTH)) u_word (
        .clk (clk),
        .rst (rst),
        .ld  (ld_s),
        .d   (wdata),
        .q   (word_s[i])
      );
    end
  end

`ifdef RF_WRITE_BYPASS_EN
  // Stored word with the strobed bytes of the incoming write overlaid.
  function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0] old_w,
                                                   input logic [WIDTH-1:0] new_w,
                                                   input logic [NB-1:0]    strb);
    logic [WIDTH-1:0] m;
    m = old_w;
    for (int b = 0; b < NB; b++) begin
      if (strb[b]) begin
        m[b*BYTE_W +: BYTE_W] = new_w[b*BYTE_W +: BYTE_W];
      end else begin
        m[b*BYTE_W +: BYTE_W] = old_w[b*BYTE_W +: BYTE_W];
      end
    end
    return m;
  endfunction
`endif

  logic [NUM_RD*WIDTH-1:0] rdata_s;
  logic [AW-1:0]           ra_s;

  // Read muxes: each port selects its word; optional write-through on address match.
  always_comb begin
    rdata_s = '0;
    ra_s    = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      ra_s = raddr[p*AW +: AW];
`ifdef RF_WRITE_BYPASS_EN
      if (we && !rst && (ra_s == waddr) && (ZERO_REG == 0 || waddr != '0)) begin
        rdata_s[p*WIDTH +: WIDTH] = merge_bytes(word_s[ra_s], wdata, wstrb);
      end else begin
        rdata_s[p*WIDTH +: WIDTH] = word_s[ra_s];
      end
`else
      rdata_s[p*WIDTH +: WIDTH] = word_s[ra_s];
`endif
    end
  end

  assign rdata = rdata_s;

endmodule

// File: tb/tb_reg_file_nr1w.sv
// Scoreboard bench for reg_file_nr1w: default RV32I instance plus a 64x8x3 instance.
module tb_reg_file_nr1w;
  import rv32i_pkg::*;

  localparam int W   = 32, D  = 32, NR  = 2, AW  = 5;
  localparam int W2  = 64, D2 = 8,  NR2 = 3, AW2 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, we;
  logic [AW-1:0]     waddr;
  logic [W-1:0]      wdata;
  logic [W/8-1:0]    wstrb;
  logic [NR*AW-1:0]  raddr;
  logic [NR*W-1:0]   rdata;

  logic              b_rst, b_we;
  logic [AW2-1:0]    b_waddr;
  logic [W2-1:0]     b_wdata;
  logic [W2/8-1:0]   b_wstrb;
  logic [NR2*AW2-1:0] b_raddr;
  logic [NR2*W2-1:0] b_rdata;

  reg_file_nr1w dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .wstrb(wstrb), .raddr(raddr), .rdata(rdata)
  );

  reg_file_nr1w #(.WIDTH(W2), .DEPTH(D2), .NUM_RD(NR2), .ZERO_REG(0)) dut64 (
    .clk(clk), .rst(b_rst), .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
    .wstrb(b_wstrb), .raddr(b_raddr), .rdata(b_rdata)
  );

  // Reference storage, updated as if each driven edge had already happened.
  logic [W-1:0]  mem  [D];
  logic [W2-1:0] mem2 [D2];

  typedef struct {
    string        name;
    logic [191:0] val;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [63:0] merge(input logic [63:0] old_w, input logic [63:0] new_w,
                                        input logic [7:0] strb, input int nbytes);
    logic [63:0] r;
    r = old_w;
    for (int b = 0; b < nbytes; b++)
      if (strb[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  // One cycle on the RV32I instance: drive, predict reads, apply write to model.
  task automatic step_a(input string name, input bit r, input bit w, input int wa,
                        input logic [31:0] wd, input logic [3:0] ws,
                        input int ra0, input int ra1, input bit chk);
    exp_t e;
    int ra [2];
    logic [63:0] t;
    logic [31:0] v;
    @(posedge clk); #1;
    rst = r; we = w; waddr = AW'(wa); wdata = wd; wstrb = ws;
    raddr = {AW'(ra1), AW'(ra0)};
    ra[0] = ra0; ra[1] = ra1;
    e.name = name; e.val = '0;
    for (int p = 0; p < 2; p++) begin
      v = (ra[p] == 0) ? 32'h0 : mem[ra[p]];
`ifdef RF_WRITE_BYPASS_EN
      if (w && !r && ra[p] == wa && wa != 0) begin
        t = merge({32'h0, v}, {32'h0, wd}, {4'h0, ws}, 4);
        v = t[31:0];
      end
`endif
      e.val[p*32 +: 32] = v;
    end
    if (chk) q_a.push_back(e);
    if (r) begin
      for (int i = 0; i < D; i++) mem[i] = 32'h0;
    end else if (w && wa != 0) begin
      t = merge({32'h0, mem[wa]}, {32'h0, wd}, {4'h0, ws}, 4);
      mem[wa] = t[31:0];
    end
  endtask

  // One cycle on the 64-bit instance (no zero register).
  task automatic step_b(input string name, input bit r, input bit w, input int wa,
                        input logic [63:0] wd, input logic [7:0] ws,
                        input int ra0, input int ra1, input int ra2, input bit chk);
    exp_t e;
    int ra [3];
    logic [63:0] v;
    @(posedge clk); #1;
    b_rst = r; b_we = w; b_waddr = AW2'(wa); b_wdata = wd; b_wstrb = ws;
    b_raddr = {AW2'(ra2), AW2'(ra1), AW2'(ra0)};
    ra[0] = ra0; ra[1] = ra1; ra[2] = ra2;
    e.name = name; e.val = '0;
    for (int p = 0; p < 3; p++) begin
      v = mem2[ra[p]];
`ifdef RF_WRITE_BYPASS_EN
      if (w && !r && ra[p] == wa) v = merge(v, wd, ws, 8);
`endif
      e.val[p*64 +: 64] = v;
    end
    if (chk) q_b.push_back(e);
    if (r) begin
      for (int i = 0; i < D2; i++) mem2[i] = 64'h0;
    end else if (w) begin
      mem2[wa] = merge(mem2[wa], wd, ws, 8);
    end
  endtask

  // Monitor: read data is stable mid-cycle; pop and compare pending expectations.
  always @(negedge clk) begin
    if (q_a.size() > 0) begin
      ea = q_a.pop_front();
      n_cmp++;
      if (rdata !== ea.val[63:0]) begin
        n_bad++;
        $display("FAIL %s: rdata=%h expected %h", ea.name, rdata, ea.val[63:0]);
      end
    end
    if (q_b.size() > 0) begin
      eb = q_b.pop_front();
      n_cmp++;
      if (b_rdata !== eb.val) begin
        n_bad++;
        $display("FAIL %s: rdata=%h expected %h", eb.name, b_rdata, eb.val);
      end
    end
  end

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; wstrb = '0; raddr = '0;
    b_rst = 1'b1; b_we = 1'b0; b_waddr = '0; b_wdata = '0; b_wstrb = '0; b_raddr = '0;

    // Reset then sweep every address on both ports.
    step_a("reset", 1'b1, 1'b0, 0, 32'h0, 4'h0, 0, 0, 1'b0);
    for (int a = 0; a < D; a++)
      step_a("reset_read", 1'b0, 1'b0, 0, 32'h0, 4'h0, a, D - 1 - a, 1'b1);

    // Full-word writes to 1..31, then readback with mirrored second port.
    for (int i = 1; i < D; i++)
      step_a("full_write", 1'b0, 1'b1, i, 32'hA5A50000 + 32'(i), 4'hF, i, 0, 1'b1);
    for (int a = 0; a < D; a++)
      step_a("full_read", 1'b0, 1'b0, 0, 32'h0, 4'h0, a, D - 1 - a, 1'b1);

    // Byte strobes: expected word 5 = 0x11BB33DD.
    step_a("strb_w1", 1'b0, 1'b1, 5, 32'h11223344, 4'hF, 5, 5, 1'b1);
    step_a("strb_w2", 1'b0, 1'b1, 5, 32'hAABBCCDD, 4'b0101, 5, 0, 1'b1);
    step_a("strb_rd", 1'b0, 1'b0, 0, 32'h0, 4'h0, 5, 5, 1'b1);
    step_a("strb_none", 1'b0, 1'b1, 5, 32'hFFFFFFFF, 4'h0, 5, 5, 1'b1);
    step_a("strb_none_rd", 1'b0, 1'b0, 0, 32'h0, 4'h0, 5, 4, 1'b1);

    // x0 ignores writes.
    step_a("x0_write", 1'b0, 1'b1, 0, 32'hDEADBEEF, 4'hF, 0, 0, 1'b1);
    step_a("x0_read", 1'b0, 1'b0, 0, 32'h0, 4'h0, 0, 0, 1'b1);

    // Same-cycle write/read of address 7, then next cycle.
    step_a("same_cycle", 1'b0, 1'b1, 7, 32'h12345678, 4'hF, 7, 7, 1'b1);
    step_a("after_write", 1'b0, 1'b0, 0, 32'h0, 4'h0, 7, 6, 1'b1);

    // Reset beats a simultaneous write.
    step_a("rst_vs_we", 1'b1, 1'b1, 3, 32'hFFFFFFFF, 4'hF, 3, 7, 1'b1);
    step_a("rst_vs_we_rd", 1'b0, 1'b0, 0, 32'h0, 4'h0, 3, 7, 1'b1);

    // Fill everything, reset mid-stream, confirm all zero.
    for (int i = 0; i < D; i++)
      step_a("refill", 1'b0, 1'b1, i, $urandom, 4'hF, i, $urandom_range(0, D - 1), 1'b1);
    step_a("mid_reset", 1'b1, 1'b0, 0, 32'h0, 4'h0, 9, 10, 1'b1);
    for (int a = 0; a < D; a++)
      step_a("post_reset", 1'b0, 1'b0, 0, 32'h0, 4'h0, a, D - 1 - a, 1'b1);

    // Random traffic on the RV32I instance.
    for (int n = 0; n < 300; n++)
      step_a("rand32", ($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
             $urandom_range(0, D - 1), $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, D - 1), $urandom_range(0, D - 1), 1'b1);

    // 64-bit, 8-deep, 3-port instance with ordinary word 0.
    step_b("b_reset", 1'b1, 1'b0, 0, 64'h0, 8'h0, 0, 0, 0, 1'b0);
    step_b("b_w0", 1'b0, 1'b1, 0, 64'h0123456789ABCDEF, 8'hFF, 1, 2, 3, 1'b1);
    step_b("b_r0", 1'b0, 1'b0, 0, 64'h0, 8'h0, 0, 0, 0, 1'b1);
    for (int n = 0; n < 1000; n++)
      step_b("rand64", ($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1,
             $urandom_range(0, D2 - 1), {$urandom, $urandom}, 8'($urandom_range(0, 255)),
             $urandom_range(0, D2 - 1), $urandom_range(0, D2 - 1),
             $urandom_range(0, D2 - 1), 1'b1);

    // Let the monitor drain, bounded.
    repeat (3) @(posedge clk);
    n_cmp++;
    if (q_a.size() + q_b.size() != 0) begin
      n_bad++;
      $display("FAIL drain: pending=%0d expected 0", q_a.size() + q_b.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
